// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (trap misaligned redirects
// instead of silently aligning them).
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  // Clears the byte-offset bits so the result is a word address.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch unit, instruction memory and decode.
//
// Handshake rules:
//   imem request : a transfer happens on a rising edge where
//                  imem_req_valid && imem_req_ready; the address is held
//                  while valid is high and ready is low.
//   imem response: imem_rsp_valid marks one data beat; there is no
//                  backpressure, the fetch unit must take or drop it.
//   decode       : an instruction transfers on a rising edge where
//                  if_valid && if_ready; if_pc/if_instr stay stable while
//                  if_valid is high and if_ready is low.
interface instr_fetch_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output if_valid, if_pc, if_instr,
    input  if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  if_valid, if_pc, if_instr,
    output if_ready
  );
endinterface

// File: rtl/fetch_out_buf.sv
// Single-entry valid/ready register slice holding {pc, instr} for decode.
// A clear wins over a load so a redirect can kill a same-cycle fill.
module fetch_out_buf #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         free
);

  // Slot can take a new entry when empty or being drained this cycle.
  assign free = !out_valid || out_ready;

  // Holds one entry until consumed; clear has priority over a fill.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one word request at a time, buffers the
// returned instruction for decode, and handles branch redirects.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pc_sel,
  input  logic [31:0]   pc_target,
  input  logic          stall,
  output logic          flush,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic          fetch_misalign,
`endif
  output fetch_state_t  dbg_state,
  instr_fetch_if.master bus
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  req_pc;
  logic         redirect;
  logic         buf_free;
  logic         buf_load;
  logic         req_fire;
  logic [31:0]  redirect_pc;

  assign redirect_pc = align_word(pc_target);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_hit;
  assign misalign_hit = pc_sel && (state != IDLE) && (pc_target[1:0] != 2'b00);
  assign redirect     = pc_sel && (state != IDLE) && !misalign_hit;

  // One-cycle trap pulse for a rejected misaligned redirect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fetch_misalign <= 1'b0;
    else          fetch_misalign <= misalign_hit;
  end
`else
  assign redirect = pc_sel && (state != IDLE);
`endif

  // Requests only go out when nothing blocks them and the result has a home.
  assign bus.imem_req_valid = (state == REQ) && !stall && !pc_sel && buf_free;
  assign bus.imem_req_addr  = (state == REQ) ? pc : '0;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  // A response fills the buffer only if it belongs to the live stream.
  assign buf_load  = (state == WAIT) && bus.imem_rsp_valid && !redirect;
  assign dbg_state = state;

  fetch_out_buf #(.W(64)) u_out_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (redirect),
    .in_valid  (buf_load),
    .in_data   ({req_pc, bus.imem_rsp_data}),
    .out_valid (bus.if_valid),
    .out_data  ({bus.if_pc, bus.if_instr}),
    .out_ready (bus.if_ready),
    .free      (buf_free)
  );

  // Fetch sequencer: pc tracking, single outstanding request, redirect drain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= '0;
      flush  <= 1'b0;
    end else begin
      flush <= redirect;
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (redirect) begin
            pc <= redirect_pc;
          end else if (req_fire) begin
            req_pc <= pc;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            pc    <= redirect_pc;
            // The in-flight word is stale; drop it now or when it arrives.
            state <= bus.imem_rsp_valid ? REQ : DRAIN;
          end else if (bus.imem_rsp_valid) begin
            pc    <= req_pc + PC_STEP;
            state <= REQ;
          end
        end
        DRAIN: begin
          if (redirect) pc <= redirect_pc;
          if (bus.imem_rsp_valid) state <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by a randomized run,
// checked against a decode-level model of the expected instruction stream.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         pc_sel;
  logic         stall;
  logic [31:0]  pc_target;
  logic         flush;
  fetch_state_t dbg_state;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic         fetch_misalign;
`endif

  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pc_sel         (pc_sel),
    .pc_target      (pc_target),
    .stall          (stall),
    .flush          (flush),
`ifdef FETCH_MISALIGN_TRAP_EN
    .fetch_misalign (fetch_misalign),
`endif
    .dbg_state      (dbg_state),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;

  logic        d_stall, d_pc_sel, d_if_ready, d_req_ready;
  logic [31:0] d_target;

  // Memory model
  logic        pending;
  logic [31:0] pend_addr;
  int          lat_cnt;
  int          mem_lat;
  logic        rand_lat;
  logic        drop;

  // Scoreboard: expected {pc, instr} stream seen by decode
  logic [63:0] exp_q[$];
  logic [31:0] next_pc;
  logic        exp_load;
  logic [31:0] exp_load_pc;
  logic        prev_taken;
  logic        prev_mis;
  int          consumed;

  // Samples from the latest step
  logic        s_if_valid, s_req_valid, s_req_fire;
  logic [31:0] s_if_pc, s_if_instr, s_req_addr;
  logic        s_flush;
  fetch_state_t s_state;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step();
    logic        rsp;
    logic        taken;
    logic [63:0] exp;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        mis;
`endif
    @(negedge clk);
    rsp = 1'b0;
    if (pending && lat_cnt == 0) rsp = 1'b1;
    else if (pending) lat_cnt--;
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? mem_word(pend_addr) : $urandom();
    stall              = d_stall;
    pc_sel             = d_pc_sel;
    pc_target          = d_target;
    bus.if_ready       = d_if_ready;
    bus.imem_req_ready = d_req_ready;
    #1;
    s_if_valid  = bus.if_valid;
    s_if_pc     = bus.if_pc;
    s_if_instr  = bus.if_instr;
    s_req_valid = bus.imem_req_valid;
    s_flush     = flush;
    s_state     = dbg_state;

    check1("flush", flush, prev_taken);
`ifdef FETCH_MISALIGN_TRAP_EN
    check1("fetch_misalign", fetch_misalign, prev_mis);
`endif
    if (exp_load) begin
      check1("load_latency_valid", bus.if_valid, 1'b1);
      check32("load_latency_pc", bus.if_pc, exp_load_pc);
    end
    if (bus.if_valid && d_if_ready) begin
      if (exp_q.size() == 0) begin
        exp_q.push_back({next_pc, mem_word(next_pc)});
        next_pc = next_pc + PC_STEP;
      end
      exp = exp_q.pop_front();
      check32("if_pc", bus.if_pc, exp[63:32]);
      check32("if_instr", bus.if_instr, exp[31:0]);
      consumed++;
    end

    s_req_fire = bus.imem_req_valid && d_req_ready;
    if (s_req_fire) check1("single_outstanding", pending, 1'b0);

`ifdef FETCH_MISALIGN_TRAP_EN
    mis   = d_pc_sel && (d_target[1:0] != 2'b00);
    taken = d_pc_sel && !mis;
    prev_mis = mis;
`else
    taken = d_pc_sel;
`endif
    exp_load    = rsp && !drop && !taken;
    exp_load_pc = pend_addr;
    if (rsp) begin
      pending = 1'b0;
      drop    = 1'b0;
    end else if (taken && pending) begin
      drop = 1'b1;
    end
    if (s_req_fire) begin
      s_req_addr = bus.imem_req_addr;
      pending    = 1'b1;
      pend_addr  = bus.imem_req_addr;
      lat_cnt    = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
    end
    if (taken) begin
      exp_q.delete();
      next_pc = d_target & 32'hFFFF_FFFC;
    end
    prev_taken = taken;
  endtask

  task automatic wait_req(input string tag, output logic [31:0] addr);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!s_req_fire && n < 40);
    check1({tag, "_timeout"}, s_req_fire, 1'b1);
    addr = s_req_addr;
  endtask

  task automatic wait_state(input string tag, input fetch_state_t st);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (s_state != st && n < 40);
    check32({tag, "_timeout"}, 32'(s_state), 32'(st));
  endtask

  // Async reset (asserted mid-cycle), reset value checks, then one IDLE
  // cycle with a stray response that must be ignored.
  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.imem_req_ready = 1'b0;
    bus.if_ready       = 1'b0;
    pc_sel = 1'b0;
    stall  = 1'b0;
    pc_target = '0;
    repeat (2) @(negedge clk);
    #1;
    check32("rst_state", 32'(dbg_state), 32'(IDLE));
    check1("rst_if_valid", bus.if_valid, 1'b0);
    check32("rst_if_pc", bus.if_pc, 32'h0);
    check32("rst_if_instr", bus.if_instr, 32'h0);
    check1("rst_req_valid", bus.imem_req_valid, 1'b0);
    check32("rst_req_addr", bus.imem_req_addr, 32'h0);
    check1("rst_flush", flush, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check1("rst_fetch_misalign", fetch_misalign, 1'b0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    bus.imem_req_ready = 1'b1;
    bus.if_ready       = 1'b1;
    #1;
    check32("idle_state", 32'(dbg_state), 32'(IDLE));
    check1("idle_no_req", bus.imem_req_valid, 1'b0);
    exp_q.delete();
    next_pc    = RST_PC;
    pending    = 1'b0;
    drop       = 1'b0;
    exp_load   = 1'b0;
    prev_taken = 1'b0;
    prev_mis   = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] addr;
    logic [31:0] hold_pc, hold_instr;
    int          n, base;

    d_stall = 1'b0; d_pc_sel = 1'b0; d_if_ready = 1'b1; d_req_ready = 1'b1;
    d_target = '0; mem_lat = 0; rand_lat = 1'b0; consumed = 0;
    pending = 1'b0; drop = 1'b0; lat_cnt = 0; pend_addr = '0;
    s_req_fire = 1'b0; s_req_addr = '0;

    // Reset and sequential fetch from RESET_PC with 1-cycle memory.
    do_reset();
    wait_req("first_req", addr);
    check32("first_req_addr", addr, RST_PC);
    base = consumed;
    repeat (10) step();
    check1("seq_progress", (consumed - base) >= 3, 1'b1);

    // Decode holds off: output frozen and no new requests.
    d_if_ready = 1'b0;
    n = 0;
    do begin step(); n++; end while (!s_if_valid && n < 20);
    check1("hold_valid_seen", s_if_valid, 1'b1);
    hold_pc = s_if_pc;
    hold_instr = s_if_instr;
    repeat (5) begin
      step();
      check1("hold_valid", s_if_valid, 1'b1);
      check32("hold_pc", s_if_pc, hold_pc);
      check32("hold_instr", s_if_instr, hold_instr);
      check1("hold_no_req", s_req_valid, 1'b0);
    end
    d_if_ready = 1'b1;

    // Redirect while waiting on memory: response dropped, refetch at target.
    mem_lat = 3;
    wait_state("wait_for_wait", WAIT);
    d_pc_sel = 1'b1; d_target = 32'h0000_0200;
    step();
    d_pc_sel = 1'b0;
    step();
    check1("wait_redirect_flush", s_flush, 1'b1);
    check32("wait_redirect_drain", 32'(s_state), 32'(DRAIN));
    wait_req("redir_req", addr);
    check32("redir_req_addr", addr, 32'h0000_0200);

    // Redirect during stall: redirect taken, fetch resumes at target.
    mem_lat = 0;
    repeat (3) step();
    d_stall = 1'b1; d_pc_sel = 1'b1; d_target = 32'h0000_0300;
    step();
    d_pc_sel = 1'b0;
    repeat (3) begin
      step();
      check1("stall_no_req", s_req_valid, 1'b0);
    end
    d_stall = 1'b0;
    wait_req("stall_redir_req", addr);
    check32("stall_redir_addr", addr, 32'h0000_0300);

    // PC wraps past the top of the address space.
    d_pc_sel = 1'b1; d_target = 32'hFFFF_FFFC;
    step();
    d_pc_sel = 1'b0;
    wait_req("top_req", addr);
    check32("top_req_addr", addr, 32'hFFFF_FFFC);
    wait_req("wrap_req", addr);
    check32("wrap_req_addr", addr, 32'h0000_0000);

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned redirect is trapped and ignored.
    repeat (2) step();
    d_pc_sel = 1'b1; d_target = 32'h0000_0202;
    step();
    d_pc_sel = 1'b0;
    step();
    check1("mis_pulse", fetch_misalign, 1'b1);
    check1("mis_no_flush", s_flush, 1'b0);
    step();
    check1("mis_pulse_end", fetch_misalign, 1'b0);
    base = consumed;
    repeat (10) step();
    check1("mis_seq_continues", (consumed - base) >= 2, 1'b1);
`else
    // Misaligned target is forced to a word boundary.
    d_pc_sel = 1'b1; d_target = 32'h0000_0207;
    step();
    d_pc_sel = 1'b0;
    wait_req("unaligned_req", addr);
    check32("unaligned_req_addr", addr, 32'h0000_0204);
`endif

    // Reset in the middle of an outstanding request.
    mem_lat = 3;
    wait_state("wait_before_reset", WAIT);
    do_reset();
    mem_lat = 0;
    wait_req("post_reset_req", addr);
    check32("post_reset_addr", addr, RST_PC);
    repeat (6) step();

    // Randomized traffic against the stream model.
    rand_lat = 1'b1;
    base = consumed;
    for (int i = 0; i < 1500; i++) begin
      d_stall     = ($urandom_range(0, 3) == 0);
      d_if_ready  = ($urandom_range(0, 9) < 7);
      d_req_ready = ($urandom_range(0, 9) < 7);
      d_pc_sel    = ($urandom_range(0, 19) == 0);
      d_target    = $urandom();
      step();
    end
    check1("random_progress", (consumed - base) >= 50, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
